// File: rtl/agc_gain_stepper.sv
// VGA gain stepper driven by the AGC controller's adjust/up_dn pair.
// Each adjust rise applies one successive-approximation step, then waits for the analog path to settle.
module agc_gain_stepper #(
  parameter int GAIN_W        = 6,
  parameter int GAIN_INIT     = 32,
  parameter int GAIN_MIN      = 0,
  parameter int GAIN_MAX      = 63,
  parameter int STEP_INIT     = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              RESETn,
  input  logic              adjust,
  input  logic              up_dn,
  output logic [GAIN_W-1:0] gain_code,
  output logic              step_pulse,
  output logic              settling,
  output logic              done,
  output logic              at_limit
);

  localparam logic [GAIN_W-1:0] INIT_G      = GAIN_W'(GAIN_INIT);
  localparam logic [GAIN_W-1:0] MIN_G       = GAIN_W'(GAIN_MIN);
  localparam logic [GAIN_W-1:0] MAX_G       = GAIN_W'(GAIN_MAX);
  localparam logic [GAIN_W-1:0] STEP_G      = GAIN_W'(STEP_INIT);
  localparam logic [GAIN_W-1:0] ONE_G       = GAIN_W'(1);
  localparam logic [GAIN_W:0]   MIN_X       = (GAIN_W+1)'(GAIN_MIN);
  localparam logic [GAIN_W:0]   MAX_X       = (GAIN_W+1)'(GAIN_MAX);
  localparam logic [7:0]        SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t            state;
  logic              adj_q;
  logic [GAIN_W-1:0] step;
  logic              last_dir;
  logic              have_dir;
  logic [7:0]        settle_cnt;

  logic              rise;
  logic              reversal;
  logic              terminal_rev;
  logic              sat_lock;
  logic [GAIN_W-1:0] step_eff;
  logic [GAIN_W:0]   up_sum;
  logic [GAIN_W:0]   dn_diff;
  logic [GAIN_W-1:0] gain_next;

  assign rise         = adjust & ~adj_q;
  assign reversal     = have_dir & (up_dn != last_dir);
  assign terminal_rev = reversal & (step == ONE_G);
  assign sat_lock     = up_dn ? (gain_code == MAX_G) : (gain_code == MIN_G);
  assign step_eff     = reversal ? (step >> 1) : step;
  assign at_limit     = (gain_code == MIN_G) | (gain_code == MAX_G);

  // One extra bit holds the carry on the way up and the borrow on the way down.
  always_comb begin
    up_sum  = {1'b0, gain_code} + {1'b0, step_eff};
    dn_diff = {1'b0, gain_code} - {1'b0, step_eff};
    if (up_dn) begin
      gain_next = (up_sum > MAX_X) ? MAX_G : up_sum[GAIN_W-1:0];
    end else begin
      gain_next = (dn_diff[GAIN_W] || (dn_diff < MIN_X)) ? MIN_G : dn_diff[GAIN_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      state      <= S_IDLE;
      adj_q      <= 1'b0;
      step       <= STEP_G;
      last_dir   <= 1'b0;
      have_dir   <= 1'b0;
      settle_cnt <= 8'd0;
      gain_code  <= INIT_G;
      step_pulse <= 1'b0;
      settling   <= 1'b0;
      done       <= 1'b0;
    end else begin
      adj_q      <= adjust;
      step_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rise) begin
            // A reversal at unit step means the search has converged.
            if (terminal_rev || sat_lock) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              step       <= step_eff;
              gain_code  <= gain_next;
              last_dir   <= up_dn;
              have_dir   <= 1'b1;
              settle_cnt <= SETTLE_LOAD;
              step_pulse <= 1'b1;
              settling   <= 1'b1;
              state      <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (settle_cnt == 8'd0) begin
            settling <= 1'b0;
            state    <= S_IDLE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        S_DONE: begin
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
